// File: rtl/plyr_move_ctrl.sv
// Player movement controller: per-frame left/right stepping with clamping, erase of the old
// sprite box, hand-off to the sprite draw engine, and muxing of both pixel streams onto the VGA port.
module plyr_move_ctrl #(
    parameter int unsigned SPR_W     = 21,
    parameter int unsigned SPR_H     = 21,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 139,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FRAME_DIV = 833333,
    parameter int unsigned START_X   = 70,
    parameter int unsigned PLYR_Y    = 96,
    parameter logic [2:0]  BG_COLOR  = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic [7:0] draw_x,
    input  logic [6:0] draw_y,
    input  logic [2:0] draw_color,
    input  logic       draw_done,
    output logic       draw_en,
    output logic [7:0] startx,
    output logic [6:0] starty,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_color,
    output logic       plot,
    output logic       busy
);

    localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [2:0] {StInit, StWaitTick, StErase, StUpdate, StDraw} state_e;

    state_e        state_q, state_d;
    logic [7:0]    pos_q, pos_d, new_q, new_d;
    logic [7:0]    ex_q, ex_d;
    logic [6:0]    ey_q, ey_d;
    logic [FW-1:0] frame_q;
    logic          tick;
    logic [8:0]    pos9, nx;

    assign tick   = (frame_q == FW'(FRAME_DIV - 1));
    assign startx = pos_q;
    assign starty = 7'(PLYR_Y);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StInit;
            pos_q   <= 8'(START_X);
            new_q   <= 8'(START_X);
            ex_q    <= '0;
            ey_q    <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            new_q   <= new_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            frame_q <= tick ? '0 : frame_q + 1'b1;
        end
    end

    // Clamp arithmetic in 9 bits so pos + STEP cannot wrap past 255.
    always_comb begin
        pos9 = {1'b0, pos_q};
        nx   = pos9;
        if (left && !right) begin
            nx = (pos9 >= 9'(X_MIN + STEP)) ? pos9 - 9'(STEP) : 9'(X_MIN);
        end else if (right && !left) begin
            nx = (pos9 + 9'(STEP) <= 9'(X_MAX)) ? pos9 + 9'(STEP) : 9'(X_MAX);
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        new_d     = new_q;
        ex_d      = ex_q;
        ey_d      = ey_q;
        draw_en   = 1'b0;
        plot      = 1'b0;
        vga_x     = '0;
        vga_y     = '0;
        vga_color = '0;
        busy      = 1'b1;
        unique case (state_q)
            StInit: state_d = StDraw;
            StWaitTick: begin
                busy = 1'b0;
                if (tick && (nx != pos9)) begin
                    new_d   = nx[7:0];
                    state_d = StErase;
                end
            end
            StErase: begin
                plot      = 1'b1;
                vga_x     = pos_q + ex_q;
                vga_y     = 7'(PLYR_Y) + ey_q;
                vga_color = BG_COLOR;
                if (ex_q == 8'(SPR_W - 1)) begin
                    ex_d = '0;
                    if (ey_q == 7'(SPR_H - 1)) begin
                        ey_d    = '0;
                        state_d = StUpdate;
                    end else begin
                        ey_d = ey_q + 1'b1;
                    end
                end else begin
                    ex_d = ex_q + 1'b1;
                end
            end
            StUpdate: begin
                pos_d   = new_q;
                state_d = StDraw;
            end
            StDraw: begin
                vga_x     = draw_x;
                vga_y     = draw_y;
                vga_color = draw_color;
                // Enable drops in the same cycle draw_done arrives.
                draw_en   = !draw_done;
                plot      = !draw_done;
                if (draw_done) state_d = StWaitTick;
            end
            default: state_d = StInit;
        endcase
    end

endmodule

// File: tb/tb_plyr_move_ctrl.sv
// Self-checking bench for plyr_move_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with hand-computed expectations.
module tb_plyr_move_ctrl;
    localparam int FD = 8;
    localparam int W = 21;
    localparam int H = 21;
    localparam int XMAX = 139;
    localparam int PY = 96;
    localparam int M_INIT = 0, M_WAIT = 1, M_ERASE = 2, M_UPDATE = 3, M_DRAW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic [7:0] draw_x = '0;
    logic [6:0] draw_y = '0;
    logic [2:0] draw_color = '0;
    logic draw_done = 1'b0;
    logic draw_en, plot, busy;
    logic [7:0] startx, vga_x;
    logic [6:0] starty, vga_y;
    logic [2:0] vga_color;

    int checks = 0;
    int passed = 0;
    bit chk_en = 0;
    int m_mode, m_pos, m_new, m_k, m_cyc;
    int lat = 442;
    int dcnt = 0;
    bit spur = 0;

    plyr_move_ctrl #(.FRAME_DIV(FD)) u_dut (
        .clock(clock), .reset(reset), .left(left), .right(right),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color), .draw_done(draw_done),
        .draw_en(draw_en), .startx(startx), .starty(starty),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .plot(plot), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int next_x(int p, logic l, logic r);
        if (l && !r) return (p - 2 < 0) ? 0 : p - 2;
        if (r && !l) return (p + 2 > XMAX) ? XMAX : p + 2;
        return p;
    endfunction

    // Model: a tick is every FD-th cycle since reset; erase is pixel index k over the box.
    always @(posedge clock) begin
        if (!reset) begin
            m_mode <= M_INIT;
            m_pos  <= 70;
            m_k    <= 0;
            m_cyc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            case (m_mode)
                M_INIT: m_mode <= M_DRAW;
                M_WAIT: if ((m_cyc % FD == FD - 1) && next_x(m_pos, left, right) != m_pos) begin
                    m_new  <= next_x(m_pos, left, right);
                    m_k    <= 0;
                    m_mode <= M_ERASE;
                end
                M_ERASE: begin
                    m_k <= m_k + 1;
                    if (m_k == W * H - 1) m_mode <= M_UPDATE;
                end
                M_UPDATE: begin
                    m_pos  <= m_new;
                    m_mode <= M_DRAW;
                end
                M_DRAW: if (draw_done) m_mode <= M_WAIT;
                default: ;
            endcase
        end
    end

    function automatic logic [35:0] expected_outputs();
        logic en, pl, bu;
        logic [7:0] vx;
        logic [6:0] vy;
        logic [2:0] vc;
        en = 0; pl = 0; vx = 0; vy = 0; vc = 0;
        bu = (m_mode != M_WAIT);
        if (m_mode == M_ERASE) begin
            pl = 1;
            vx = 8'(m_pos + m_k % W);
            vy = 7'(PY + m_k / W);
        end else if (m_mode == M_DRAW) begin
            en = !draw_done;
            pl = !draw_done;
            vx = draw_x; vy = draw_y; vc = draw_color;
        end
        return {en, pl, bu, 8'(m_pos), 7'(PY), vx, vy, vc};
    endfunction

    always @(negedge clock) begin
        if (chk_en)
            check("outputs", 64'({draw_en, plot, busy, startx, starty, vga_x, vga_y, vga_color}),
                  64'(expected_outputs()));
    end

    // Draw engine stand-in: done after lat cycles in DRAW; spur injects a stray done.
    initial forever begin
        @(posedge clock);
        #1;
        if (m_mode == M_DRAW) dcnt++;
        else dcnt = 0;
        draw_done  = ((m_mode == M_DRAW) && dcnt >= lat) || spur;
        draw_x     = 8'(dcnt * 7 + 3);
        draw_y     = 7'(dcnt * 5);
        draw_color = 3'(dcnt);
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_busy(input logic v, input int budget, input string name);
        int n = 0;
        while (busy !== v && n < budget) begin cyc(); n++; end
        check(name, 64'(busy), 64'(v));
    endtask

    task automatic wait_pos(input int p, input int budget, input string name);
        int n = 0;
        while (!(startx == 8'(p) && busy == 1'b0) && n < budget) begin cyc(); n++; end
        check(name, 64'(startx), 64'(p));
    endtask

    task automatic idle_frames(input string name);
        int pc = 0, bc = 0;
        for (int i = 0; i < 3 * FD; i++) begin
            cyc();
            if (plot) pc++;
            if (busy) bc++;
        end
        check({name, "_plot"}, 64'(pc), 64'(0));
        check({name, "_busy"}, 64'(bc), 64'(0));
    endtask

    initial begin
        int n, lx, ly, pc, bc;
        @(posedge clock);
        #1;
        chk_en = 1;
        repeat (2) cyc();
        check("reset_busy", 64'(busy), 64'(1));
        check("reset_plot", 64'(plot), 64'(0));
        check("reset_startx", 64'(startx), 64'(70));
        check("reset_vga", 64'({vga_x, vga_y, vga_color}), 64'(0));

        // Initial paint, no erase.
        reset = 1;
        cyc();
        check("init_draw_en", 64'(draw_en), 64'(1));
        check("init_startx", 64'(startx), 64'(70));
        check("init_starty", 64'(starty), 64'(96));
        n = 0;
        while (busy && n < 600) begin cyc(); n++; end
        check("init_draw_cycles", 64'(n), 64'(442));
        check("init_draw_en_off", 64'(draw_en), 64'(0));
        lat = 4;

        // Right move from 70.
        right = 1;
        wait_busy(1, 2 * FD + 2, "right_start");
        right = 0;
        check("erase_first", 64'({plot, vga_x, vga_y, vga_color}), 64'({1'b1, 8'd70, 7'd96, 3'd0}));
        n = 0; lx = 0; ly = 0;
        while (plot && n < 1000) begin
            lx = vga_x; ly = vga_y;
            cyc(); n++;
        end
        check("erase_count", 64'(n), 64'(441));
        check("erase_last", 64'({lx[7:0], ly[6:0]}), 64'({8'd90, 7'd116}));
        check("update_cycle", 64'({plot, busy, startx}), 64'({1'b0, 1'b1, 8'd70}));
        cyc();
        check("moved_draw", 64'({draw_en, startx}), 64'({1'b1, 8'd72}));
        wait_busy(0, 20, "moved_done");

        // Both held, plus a stray draw_done in WAIT_TICK.
        left = 1; right = 1; pc = 0; bc = 0;
        for (int i = 0; i < 3 * FD; i++) begin
            spur = (i == 5);
            cyc();
            if (plot) pc++;
            if (busy) bc++;
        end
        spur = 0;
        check("both_plot", 64'(pc), 64'(0));
        check("both_busy", 64'(bc), 64'(0));
        left = 0; right = 0;
        cyc();

        // Long draw so a tick lands in DRAW; next move waits for a fresh tick.
        lat = 20;
        right = 1;
        wait_busy(1, 2 * FD + 2, "tickdraw_start");
        n = 0;
        while (!draw_en && n < 600) begin cyc(); n++; end
        wait_busy(0, 60, "tickdraw_done");
        n = 0;
        while (!busy && n < 2 * FD) begin cyc(); n++; end
        check("tickdraw_gap", 64'(n >= 1 && n <= FD), 64'(1));
        lat = 4;

        // Sweep to the right limit (odd clamp to 139), then clamped idle.
        wait_pos(XMAX, 25000, "reach_xmax");
        idle_frames("xmax_clamp");

        // Sweep left down to 1, then clamp to 0.
        right = 0; left = 1;
        wait_pos(1, 40000, "reach_x1");
        wait_pos(0, 600, "reach_x0");
        idle_frames("xmin_clamp");
        left = 0;

        // Reset in the middle of an erase.
        right = 1;
        wait_busy(1, 2 * FD + 2, "abort_start");
        right = 0;
        repeat (200) cyc();
        check("pix200", 64'({vga_x, vga_y, plot}), 64'({8'd11, 7'd105, 1'b1}));
        reset = 0;
        cyc();
        check("abort_out", 64'({plot, vga_x, vga_y, vga_color, busy, startx}),
              64'({1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd70}));
        reset = 1;
        cyc();
        check("abort_redraw", 64'({draw_en, startx}), 64'({1'b1, 8'd70}));
        wait_busy(0, 20, "abort_done");
        repeat (4) cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
